// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_tx_arbiter_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer-side request bus and transmitter load/data bus of the arbiter.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = UART_DW
);
  localparam int GW = idx_w(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               tx_load;
  logic [DW-1:0]      tx_data;
  logic               tx_busy;
  logic [GW-1:0]      grant_id;
  logic               active;
  logic               timeout_err;

  modport master (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_load, tx_data, grant_id, active, timeout_err
  );

  modport slave (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_load, tx_data, grant_id, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = 4
)(
  input  logic [NREQ-1:0]        req,
  input  logic [idx_w(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]        gnt,
  output logic [idx_w(NREQ)-1:0] gnt_idx,
  output logic                   any
);
  localparam int GW = idx_w(NREQ);

  int unsigned idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ byte producers with round-robin grant,
// one-cycle load pulse and a start timeout on tx_busy.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int DW            = UART_DW,
  parameter int START_TIMEOUT = 16
)(
  input logic             clk,
  input logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int GW = idx_w(NREQ);
  localparam int CW = idx_w(START_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [GW-1:0] IDX_LAST = GW'(NREQ - 1);

  state_t          state, state_n;
  logic [GW-1:0]   ptr, ptr_n, gnt_idx, grant_q;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic [CW-1:0]   cnt, cnt_n;
  logic            load_q, load_n;
  logic            active_q, active_n;
  logic            terr_q, terr_n;
  logic            accept;
  logic [DW-1:0]   data_q, sel_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) sel_data = bus.req_data[i*DW +: DW];
    end
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cnt_n    = cnt;
    load_n   = 1'b0;
    active_n = active_q;
    terr_n   = 1'b0;
    accept   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!bus.tx_busy && any) begin
          accept   = 1'b1;
          load_n   = 1'b1;
          active_n = 1'b1;
          ptr_n    = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
          state_n  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_n   = '0;
        state_n = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (bus.tx_busy) begin
          state_n = ST_WAIT_DONE;
        end else if (cnt == TO_LAST) begin
          terr_n   = 1'b1;
          active_n = 1'b0;
          state_n  = ST_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          active_n = 1'b0;
          state_n  = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      load_q   <= 1'b0;
      active_q <= 1'b0;
      terr_q   <= 1'b0;
      data_q   <= '0;
      grant_q  <= '0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      cnt      <= cnt_n;
      load_q   <= load_n;
      active_q <= active_n;
      terr_q   <= terr_n;
      if (accept) begin
        data_q  <= sel_data;
        grant_q <= gnt_idx;
      end
    end
  end

  // Ready is the only combinational output; gated by rst so it reads 0 while reset is held.
  assign bus.req_ready   = (state == ST_IDLE && !bus.tx_busy && !rst) ? gnt : '0;
  assign bus.tx_load     = load_q;
  assign bus.tx_data     = data_q;
  assign bus.grant_id    = grant_q;
  assign bus.active      = active_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter (NREQ=4, DW=8, START_TIMEOUT=16).
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  uart_tx_arbiter #(.NREQ(4), .DW(8), .START_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        busy;
    logic [3:0]  rdy;
    logic        load;
    logic        act;
    logic [1:0]  gid;
    logic [7:0]  txd;
    logic        terr;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.tx_busy   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic void add(input logic [3:0] v, input logic [31:0] d, input logic busy,
                              input logic [3:0] rdy, input logic load, input logic act,
                              input logic [1:0] gid, input logic [7:0] txd, input logic terr);
    vec_t e;
    e.v = v; e.d = d; e.busy = busy; e.rdy = rdy; e.load = load;
    e.act = act; e.gid = gid; e.txd = txd; e.terr = terr;
    tbl.push_back(e);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;

    // All four requesters held valid from reset: grants 0,1,2,3 then back to 0.
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = k % 4;
      add(4'hF, 32'h1312_1110, 1'b0, 4'(1 << idx), 1'b0, 1'b0,
          (k == 0) ? 2'd0 : 2'((k - 1) % 4),
          (k == 0) ? 8'h00 : 8'(8'h10 + (k - 1) % 4), 1'b0);
      add(4'hF, 32'h1312_1110, 1'b0, 4'b0000, 1'b1, 1'b1, 2'(idx), 8'(8'h10 + idx), 1'b0);
      add(4'hF, 32'h1312_1110, 1'b1, 4'b0000, 1'b0, 1'b1, 2'(idx), 8'(8'h10 + idx), 1'b0);
      add(4'hF, 32'h1312_1110, 1'b0, 4'b0000, 1'b0, 1'b1, 2'(idx), 8'(8'h10 + idx), 1'b0);
    end
    // Single requester 2 with byte A5, longer busy phase.
    add(4'b0100, 32'h00A5_0000, 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 8'h10, 1'b0);
    add(4'b0000, 32'h00A5_0000, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2, 8'hA5, 1'b0);
    add(4'b0000, 32'h00A5_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b0);
    add(4'b0000, 32'h00A5_0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b0);
    add(4'b0000, 32'h00A5_0000, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2, 8'hA5, 1'b0);
    add(4'b0000, 32'h00A5_0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b0);

    // Reset values, then 50 idle cycles.
    do_reset();
    chk("rst_ready", 32'(bus.req_ready), 0);
    chk("rst_load", 32'(bus.tx_load), 0);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_grant", 32'(bus.grant_id), 0);
    chk("rst_txdata", 32'(bus.tx_data), 0);
    chk("rst_terr", 32'(bus.timeout_err), 0);
    for (int i = 0; i < 50; i++) begin
      chk("idle_quiet", 32'({bus.req_ready, bus.tx_load, bus.active}), 0);
      step();
    end

    // Table-driven vectors.
    do_reset();
    foreach (tbl[i]) begin
      bus.req_valid = tbl[i].v;
      bus.req_data  = tbl[i].d;
      bus.tx_busy   = tbl[i].busy;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].rdy));
      chk($sformatf("v%0d_load", i), 32'(bus.tx_load), 32'(tbl[i].load));
      chk($sformatf("v%0d_active", i), 32'(bus.active), 32'(tbl[i].act));
      chk($sformatf("v%0d_grant", i), 32'(bus.grant_id), 32'(tbl[i].gid));
      chk($sformatf("v%0d_txdata", i), 32'(bus.tx_data), 32'(tbl[i].txd));
      chk($sformatf("v%0d_terr", i), 32'(bus.timeout_err), 32'(tbl[i].terr));
      step();
    end

    // Start timeout: busy never rises after the grant.
    do_reset();
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_0077;
    #1;
    chk("to_ready", 32'(bus.req_ready), 32'h1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      bus.req_valid = '0;
      if (i == 1) chk("to_load", 32'(bus.tx_load), 1);
      if (bus.timeout_err) begin
        n = i;
        break;
      end
    end
    chk("to_latency", 32'(n), 18);
    chk("to_active_drop", 32'(bus.active), 0);
    step();
    chk("to_pulse_width", 32'(bus.timeout_err), 0);
    bus.req_valid = 4'b0010;
    bus.req_data  = 32'h0000_5C00;
    #1;
    chk("to_next_ready", 32'(bus.req_ready), 32'h2);
    step();
    chk("to_next_load", 32'(bus.tx_load), 1);
    chk("to_next_grant", 32'(bus.grant_id), 1);
    chk("to_next_txdata", 32'(bus.tx_data), 32'h5C);

    // Reset during WAIT_DONE with requester 1 still valid.
    bus.tx_busy = 1'b1;
    step();
    step();
    chk("wd_active", 32'(bus.active), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(bus.req_ready), 0);
    chk("mid_rst_load", 32'(bus.tx_load), 0);
    chk("mid_rst_active", 32'(bus.active), 0);
    chk("mid_rst_grant", 32'(bus.grant_id), 0);
    chk("mid_rst_txdata", 32'(bus.tx_data), 0);
    bus.tx_busy = 1'b0;
    step();
    step();
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("post_rst_ready", 32'(bus.req_ready), 0);
    step();
    chk("post_rst_noload", 32'(bus.tx_load), 0);
    bus.req_valid = 4'b0110;
    bus.req_data  = 32'h0000_5C00;
    #1;
    chk("post_rst_ptr0", 32'(bus.req_ready), 32'h2);
    step();
    chk("post_rst_load", 32'(bus.tx_load), 1);
    chk("post_rst_grant", 32'(bus.grant_id), 1);

    // Foreign busy while idle blocks the grant until it falls.
    do_reset();
    bus.tx_busy   = 1'b1;
    bus.req_valid = 4'b0001;
    bus.req_data  = 32'h0000_003C;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("busy_block", 32'({bus.req_ready, bus.tx_load}), 0);
      step();
    end
    bus.tx_busy = 1'b0;
    #1;
    chk("busy_release_ready", 32'(bus.req_ready), 32'h1);
    step();
    chk("busy_release_load", 32'(bus.tx_load), 1);
    chk("busy_release_grant", 32'(bus.grant_id), 0);
    chk("busy_release_txdata", 32'(bus.tx_data), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
